// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and operand/result types for the quotient unit.
// The width constants are common with the upstream reciprocal stage.
package div_pkg;

   localparam int unsigned ARG_BIT_WIDTH = 32;
   localparam int unsigned PRECISION     = 64;
   localparam int unsigned CNT_WIDTH     = $clog2(ARG_BIT_WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, MUL, REM, CORR, DONE} div_state_t;

   typedef logic [ARG_BIT_WIDTH-1:0] arg_t;
   typedef logic [PRECISION-1:0]     rec_t;
   typedef logic [ARG_BIT_WIDTH:0]   rem_ext_t;

   typedef struct packed {
      arg_t quotient;
      arg_t remainder;
      logic dvz_err;
   } result_t;

endpackage

// File: rtl/recip_quotient_unit_if.sv
// Operand/result handshake bundle between the reciprocal stage, the quotient unit and
// its consumer.
interface recip_quotient_unit_if;
   import div_pkg::*;

   logic in_valid;
   logic in_ready;
   arg_t a;
   arg_t b;
   rec_t rec;
   logic dvz;
   logic out_valid;
   logic out_ready;
   arg_t quotient;
   arg_t remainder;
   logic dvz_err;

   modport master (
      output in_valid, a, b, rec, dvz, out_ready,
      input  in_ready, out_valid, quotient, remainder, dvz_err
   );

   modport slave (
      input  in_valid, a, b, rec, dvz, out_ready,
      output in_ready, out_valid, quotient, remainder, dvz_err
   );

endinterface

// File: rtl/seq_shift_add_mul.sv
// Serial LSB-first shift-add multiplier with a truncated accumulator.
// start_i loads the operands and performs the first step in the same cycle.
module seq_shift_add_mul #(
   parameter int unsigned McandWidth  = 64,
   parameter int unsigned MplierWidth = 32,
   parameter int unsigned AccWidth    = 96,
   parameter int unsigned OutLsb      = 64,
   parameter int unsigned OutWidth    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [McandWidth-1:0]  mcand_i,
   input  logic [MplierWidth-1:0] mplier_i,
   output logic                   done_o,
   output logic [OutWidth-1:0]    prod_o
);

   localparam int unsigned CntWidth = $clog2(MplierWidth) + 1;

   typedef logic [AccWidth-1:0] acc_t;

   acc_t                   acc_q, acc_d;
   acc_t                   mcand_q, mcand_d;
   acc_t                   mcand_ext;
   logic [MplierWidth-1:0] mplier_q, mplier_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic                   done_q, done_d;

   // Bits shifted past AccWidth are dropped, giving the product modulo 2^AccWidth.
   assign mcand_ext = acc_t'(mcand_i);

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      if (start_i) begin
         acc_d    = mplier_i[0] ? mcand_ext : '0;
         mcand_d  = mcand_ext << 1;
         mplier_d = mplier_i >> 1;
         cnt_d    = CntWidth'(MplierWidth - 1);
      end else if (cnt_q != '0) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CntWidth'(1);
         done_d   = (cnt_q == CntWidth'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   assign done_o = done_q;
   assign prod_o = acc_q[OutLsb +: OutWidth];

endmodule

// File: rtl/recip_quotient_unit.sv
// Turns a Q0.PRECISION reciprocal into an exact quotient/remainder: estimate by multiply,
// back-multiply for the remainder, then one correction step.
module recip_quotient_unit
   import div_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   recip_quotient_unit_if.slave bus
);

   div_state_t state_q, state_d;
   arg_t       a_q, a_d;
   arg_t       b_q, b_d;
   result_t    res_q, res_d;
   logic       out_valid_q, out_valid_d;
   logic       in_ready_q, in_ready_d;

   logic       accept;
   logic       mul_start, mul_done;
   logic       rem_start, rem_done;
   arg_t       q_est;
   rem_ext_t   rem_prod;
   rem_ext_t   r_ext;

   assign accept    = bus.in_valid && in_ready_q;
   assign mul_start = accept && !bus.dvz;
   assign rem_start = (state_q == MUL) && mul_done;

   // q_est is at most one short, so the difference always fits in one extra bit.
   assign r_ext = {1'b0, a_q} - rem_prod;

   seq_shift_add_mul #(
      .McandWidth  (PRECISION),
      .MplierWidth (ARG_BIT_WIDTH),
      .AccWidth    (PRECISION + ARG_BIT_WIDTH),
      .OutLsb      (PRECISION),
      .OutWidth    (ARG_BIT_WIDTH)
   ) u_mul_est (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mul_start),
      .mcand_i  (bus.rec),
      .mplier_i (bus.a),
      .done_o   (mul_done),
      .prod_o   (q_est)
   );

   seq_shift_add_mul #(
      .McandWidth  (ARG_BIT_WIDTH),
      .MplierWidth (ARG_BIT_WIDTH),
      .AccWidth    (ARG_BIT_WIDTH + 1),
      .OutLsb      (0),
      .OutWidth    (ARG_BIT_WIDTH + 1)
   ) u_mul_rem (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (rem_start),
      .mcand_i  (q_est),
      .mplier_i (b_q),
      .done_o   (rem_done),
      .prod_o   (rem_prod)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d = bus.a;
               b_d = bus.b;
               if (bus.dvz) begin
                  res_d.quotient  = '1;
                  res_d.remainder = bus.a;
                  res_d.dvz_err   = 1'b1;
                  state_d         = DONE;
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: if (mul_done) state_d = REM;
         REM: if (rem_done) state_d = CORR;
         CORR: begin
            if (r_ext >= {1'b0, b_q}) begin
               res_d.quotient  = q_est + arg_t'(1);
               res_d.remainder = r_ext[ARG_BIT_WIDTH-1:0] - b_q;
            end else begin
               res_d.quotient  = q_est;
               res_d.remainder = r_ext[ARG_BIT_WIDTH-1:0];
            end
            res_d.dvz_err = 1'b0;
            state_d       = DONE;
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = res_q.quotient;
   assign bus.remainder = res_q.remainder;
   assign bus.dvz_err   = res_q.dvz_err;

endmodule
